// File: rtl/int_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : int_div_pkg
//  Description : Shared types and constants for the iterative 32-bit
//                integer divider (FSM states, message field positions,
//                divide-by-zero quotient, negate helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package int_div_pkg;

   // Control FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Request message fields
   localparam int c_MSG_SIGNED_BIT = 64;
   localparam int c_DIVIDEND_MSB   = 63;
   localparam int c_DIVIDEND_LSB   = 32;
   localparam int c_DIVISOR_MSB    = 31;
   localparam int c_DIVISOR_LSB    = 0;

   // Result message fields
   localparam int c_QUOTIENT_MSB   = 63;
   localparam int c_QUOTIENT_LSB   = 32;
   localparam int c_REMAINDER_MSB  = 31;
   localparam int c_REMAINDER_LSB  = 0;

   // Quotient reported for a zero divisor
   localparam logic [31:0] c_DIV_ZERO_QUO = 32'hFFFF_FFFF;

   // Counter value of the final shift-subtract step
   localparam logic [4:0] c_LAST_STEP = 5'd31;

   // Two's-complement negate, mod 2^32
   function automatic logic [31:0] neg32(input logic [31:0] x);
      return ~x + 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/int_div_iterative_dpath.sv
`default_nettype none
// ============================================================================
//  Module      : int_div_iterative_dpath
//  Description : Datapath for the iterative divider: operand magnitudes,
//                {rem,quo} shift register, divisor register, shift-subtract
//                step, sign correction and result register.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_div_iterative_dpath
   import int_div_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [64:0] i_msg,
   input  logic        i_load,       // latch operands (accept cycle)
   input  logic        i_load_dz,    // write divide-by-zero result
   input  logic        i_step,       // one shift-subtract iteration
   input  logic        i_finish,     // last iteration: write corrected result
   output logic        o_divisor_zero,
   output logic [63:0] o_msg
);

   logic [63:0] r_remquo;
   logic [31:0] r_divisor;
   logic        r_neg_q;
   logic        r_neg_r;
   logic [63:0] r_out;

   logic        w_signed;
   logic [31:0] w_dividend;
   logic [31:0] w_divisor;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [32:0] w_rem_sh;
   logic [31:0] w_quo_sh;
   logic [33:0] w_diff;
   logic        w_fits;
   logic [63:0] w_remquo_nxt;
   logic [31:0] w_q_fix;
   logic [31:0] w_r_fix;

   assign w_signed   = i_msg[c_MSG_SIGNED_BIT];
   assign w_dividend = i_msg[c_DIVIDEND_MSB:c_DIVIDEND_LSB];
   assign w_divisor  = i_msg[c_DIVISOR_MSB:c_DIVISOR_LSB];

   assign o_divisor_zero = (w_divisor == 32'd0);

   assign w_a_neg = w_signed & w_dividend[31];
   assign w_b_neg = w_signed & w_divisor[31];
   assign w_a_mag = w_a_neg ? neg32(w_dividend) : w_dividend;
   assign w_b_mag = w_b_neg ? neg32(w_divisor)  : w_divisor;

   // The shifted remainder keeps the bit shifted out of rem[31]: with a
   // divisor above 2^31 the partial remainder can exceed 32 bits.
   assign w_rem_sh = r_remquo[63:31];
   assign w_quo_sh = {r_remquo[30:0], 1'b0};
   assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_divisor};
   // No borrow leaves a difference below the divisor, so both top bits are
   // zero exactly when the subtraction succeeds.
   assign w_fits   = ~|w_diff[33:32];

   assign w_remquo_nxt = w_fits ? {w_diff[31:0], w_quo_sh[31:1], 1'b1}
                                : {w_rem_sh[31:0], w_quo_sh};

   assign w_q_fix = r_neg_q ? neg32(w_remquo_nxt[31:0])  : w_remquo_nxt[31:0];
   assign w_r_fix = r_neg_r ? neg32(w_remquo_nxt[63:32]) : w_remquo_nxt[63:32];

   // Operand/iteration registers: load magnitudes on accept, step during CALC
   always_ff @(posedge clk) begin
      if (reset) begin
         r_remquo  <= 64'd0;
         r_divisor <= 32'd0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
      end else if (i_load) begin
         r_remquo  <= {32'd0, w_a_mag};
         r_divisor <= w_b_mag;
         r_neg_q   <= w_a_neg ^ w_b_neg;
         r_neg_r   <= w_a_neg;
      end else if (i_step) begin
         r_remquo  <= w_remquo_nxt;
      end
   end

   // Result register: held stable until the next result is written
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out <= 64'd0;
      end else if (i_load_dz) begin
         r_out <= {c_DIV_ZERO_QUO, w_dividend};
      end else if (i_finish) begin
         r_out <= {w_q_fix, w_r_fix};
      end
   end

   assign o_msg = r_out;

endmodule
`default_nettype wire

// File: rtl/int_div_iterative.sv
`default_nettype none
// ============================================================================
//  Module      : int_div_iterative
//  Description : Iterative 32-bit DIV/DIVU/REM/REMU unit, one quotient bit
//                per cycle, val/rdy request and response streams.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_div_iterative
   import int_div_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        istream_val,
   output logic        istream_rdy,
   input  logic [64:0] istream_msg,
   output logic        ostream_val,
   input  logic        ostream_rdy,
   output logic [63:0] ostream_msg
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [4:0]  r_cnt;

   logic        w_load;
   logic        w_load_dz;
   logic        w_step;
   logic        w_finish;
   logic        w_divisor_zero;

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Iteration counter: runs 0..31 across CALC, parked at 0 elsewhere
   always_ff @(posedge clk) begin
      if (reset)                  r_cnt <= 5'd0;
      else if (r_state == ST_CALC) r_cnt <= r_cnt + 5'd1;
      else                        r_cnt <= 5'd0;
   end

   // Next-state, handshake outputs and datapath controls
   always_comb begin
      w_state_nxt = r_state;
      istream_rdy = 1'b0;
      ostream_val = 1'b0;
      w_load      = 1'b0;
      w_load_dz   = 1'b0;
      w_step      = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            istream_rdy = 1'b1;
            if (istream_val) begin
               w_load = 1'b1;
               if (w_divisor_zero) begin
                  w_load_dz   = 1'b1;
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            w_step = 1'b1;
            if (r_cnt == c_LAST_STEP) begin
               w_finish    = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            ostream_val = 1'b1;
            if (ostream_rdy) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   int_div_iterative_dpath u_dpath (
      .clk            (clk),
      .reset          (reset),
      .i_msg          (istream_msg),
      .i_load         (w_load),
      .i_load_dz      (w_load_dz),
      .i_step         (w_step),
      .i_finish       (w_finish),
      .o_divisor_zero (w_divisor_zero),
      .o_msg          (ostream_msg)
   );

endmodule
`default_nettype wire
